rx_alu_interface: RTL and testbench



---
 rtl/rx_alu_interface.sv | 150 +++++++++++++++
 tb/tb_rx_alu_interface.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/rx_alu_interface.sv
// rx_alu_interface
//   Collects three bytes from the UART receiver (operand A, operand B,
//   opcode), presents them to an external combinational ALU, captures the
//   ALU result and hands it to the UART transmitter.
//
//   Optional build macro ALU_IF_TIMEOUT_EN: when defined, an inter-byte
//   timeout returns a stalled WAIT_B/WAIT_OP back to WAIT_A after
//   TIMEOUT_CYCLES cycles. When undefined, those states wait indefinitely.
//
// Ports
//   clk           system clock, rising edge
//   reset         asynchronous, active-high reset
//   rx_done_tick  one-cycle pulse, rx_data holds a new byte
//   rx_data       received byte
//   alu_result    combinational ALU output
//   tx_done_tick  one-cycle pulse, transmitter finished a byte
//   alu_a/alu_b   registered operands
//   alu_op        registered opcode (low N_OP bits of the third byte)
//   tx_start      one-cycle transmit request (decoded from state)
//   tx_data       byte to transmit
//   busy          high while a result is being computed or sent
//
// States
//   WAIT_A  | waiting for operand A
//   WAIT_B  | waiting for operand B
//   WAIT_OP | waiting for opcode
//   CALC    | ALU settle cycle, result captured on exit
//   SEND    | tx_start asserted
//   WAIT_TX | waiting for the transmitter to finish
module rx_alu_interface #(
  parameter int N_BITS         = 8,
  parameter int N_OP           = 6,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_done_tick,
  input  logic [N_BITS-1:0] rx_data,
  input  logic [N_BITS-1:0] alu_result,
  input  logic              tx_done_tick,
  output logic [N_BITS-1:0] alu_a,
  output logic [N_BITS-1:0] alu_b,
  output logic [N_OP-1:0]   alu_op,
  output logic              tx_start,
  output logic [N_BITS-1:0] tx_data,
  output logic              busy
);

  typedef enum logic [2:0] {
    WAIT_A, WAIT_B, WAIT_OP, CALC, SEND, WAIT_TX
  } state_t;

  state_t            state_q, state_d;
  logic [N_BITS-1:0] alu_a_q, alu_a_d;
  logic [N_BITS-1:0] alu_b_q, alu_b_d;
  logic [N_OP-1:0]   alu_op_q, alu_op_d;
  logic [N_BITS-1:0] tx_data_q, tx_data_d;
  logic              timeout_hit;

`ifdef ALU_IF_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          in_wait_byte;

  assign in_wait_byte = (state_q == WAIT_B) || (state_q == WAIT_OP);
  assign timeout_hit  = in_wait_byte && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  // Counter is zero everywhere except while idling between bytes; an
  // accepted byte or an expiry both bring it back to zero.
  always_comb begin
    cnt_d = '0;
    if (in_wait_byte && !rx_done_tick && !timeout_hit) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  assign timeout_hit = 1'b0;
  // The timeout length only matters when the timeout is compiled in.
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

  always_comb begin
    state_d   = state_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_op_d  = alu_op_q;
    tx_data_d = tx_data_q;
    case (state_q)
      WAIT_A: begin
        if (rx_done_tick) begin
          alu_a_d = rx_data;
          state_d = WAIT_B;
        end
      end
      WAIT_B: begin
        // A byte arriving on the expiry cycle still counts.
        if (rx_done_tick) begin
          alu_b_d = rx_data;
          state_d = WAIT_OP;
        end else if (timeout_hit) begin
          state_d = WAIT_A;
        end
      end
      WAIT_OP: begin
        if (rx_done_tick) begin
          alu_op_d = rx_data[N_OP-1:0];
          state_d  = CALC;
        end else if (timeout_hit) begin
          state_d = WAIT_A;
        end
      end
      CALC: begin
        tx_data_d = alu_result;
        state_d   = SEND;
      end
      SEND:    state_d = WAIT_TX;
      WAIT_TX: if (tx_done_tick) state_d = WAIT_A;
      default: state_d = WAIT_A;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= WAIT_A;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_op_q  <= '0;
      tx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_op_q  <= alu_op_d;
      tx_data_q <= tx_data_d;
    end
  end

  assign alu_a    = alu_a_q;
  assign alu_b    = alu_b_q;
  assign alu_op   = alu_op_q;
  assign tx_data  = tx_data_q;
  assign tx_start = (state_q == SEND);
  assign busy     = (state_q == CALC) || (state_q == SEND) || (state_q == WAIT_TX);

endmodule

// File: tb/tb_rx_alu_interface.sv
module tb_rx_alu_interface;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_done_tick = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic [7:0] alu_result;
  logic       tx_done_tick = 1'b0;
  logic [7:0] alu_a, alu_b, tx_data;
  logic [5:0] alu_op;
  logic       tx_start, busy;

  int checks = 0;
  int failures = 0;
  int pulse_cnt = 0;

  rx_alu_interface #(.N_BITS(8), .N_OP(6), .TIMEOUT_CYCLES(50)) dut (
    .clk(clk), .reset(reset), .rx_done_tick(rx_done_tick), .rx_data(rx_data),
    .alu_result(alu_result), .tx_done_tick(tx_done_tick), .alu_a(alu_a),
    .alu_b(alu_b), .alu_op(alu_op), .tx_start(tx_start), .tx_data(tx_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // External ALU: MIPS-style function codes.
  function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                         input logic [5:0] op);
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      6'h27:   return ~(a | b);
      default: return 8'h00;
    endcase
  endfunction

  assign alu_result = alu_ref(alu_a, alu_b, alu_op);

  always @(negedge clk) if (tx_start === 1'b1) pulse_cnt++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data      = b;
    rx_done_tick = 1'b1;
    tick();
    rx_done_tick = 1'b0;
  endtask

  // Idle gap between bytes; stray tx_done_tick pulses here must be ignored.
  task automatic idle_rand(input int max_gap);
    int n;
    n = $urandom_range(0, max_gap);
    for (int i = 0; i < n; i++) begin
      tx_done_tick = 1'($urandom_range(0, 1));
      tick();
      tx_done_tick = 1'b0;
    end
  endtask

  // Post-opcode checks. inject: 0 none, 1 extra rx byte in WAIT_TX,
  // 2 rx byte in the same cycle as tx_done_tick.
  task automatic finish_seq(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                            input logic [7:0] exp_res, input int inject);
    checks++; if (alu_a !== a) begin failures++; $display("FAIL alu_a got=%h exp=%h", alu_a, a); end
    checks++; if (alu_b !== b) begin failures++; $display("FAIL alu_b got=%h exp=%h", alu_b, b); end
    checks++; if (alu_op !== opb[5:0]) begin failures++; $display("FAIL alu_op got=%h exp=%h", alu_op, opb[5:0]); end
    checks++; if (tx_start !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL calc_flags start=%b busy=%b exp start=0 busy=1", tx_start, busy); end
    tick();
    checks++; if (tx_start !== 1'b1) begin failures++; $display("FAIL tx_start_pulse got=%b exp=1", tx_start); end
    checks++; if (tx_data !== exp_res) begin failures++; $display("FAIL tx_data got=%h exp=%h", tx_data, exp_res); end
    tick();
    checks++; if (tx_start !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL wait_tx_flags start=%b busy=%b exp start=0 busy=1", tx_start, busy); end
    repeat ($urandom_range(0, 3)) tick();
    if (inject == 1) begin
      send_byte(8'hAA);
      checks++; if (alu_a !== a || alu_b !== b || busy !== 1'b1) begin failures++; $display("FAIL drop_in_wait_tx alu_a=%h alu_b=%h busy=%b exp %h %h 1", alu_a, alu_b, busy, a, b); end
    end
    tx_done_tick = 1'b1;
    if (inject == 2) begin rx_data = 8'hAA; rx_done_tick = 1'b1; end
    tick();
    tx_done_tick = 1'b0;
    rx_done_tick = 1'b0;
    checks++; if (busy !== 1'b0 || tx_start !== 1'b0) begin failures++; $display("FAIL done_flags busy=%b start=%b exp 0 0", busy, tx_start); end
    checks++; if (tx_data !== exp_res || alu_a !== a) begin failures++; $display("FAIL hold_after_done tx_data=%h alu_a=%h exp %h %h", tx_data, alu_a, exp_res, a); end
  endtask

  task automatic run_seq(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                         input logic [7:0] exp_res, input int max_gap, input int inject);
    send_byte(a);
    idle_rand(max_gap);
    send_byte(b);
    idle_rand(max_gap);
    send_byte(opb);
    finish_seq(a, b, opb, exp_res, inject);
  endtask

  task automatic test_reset();
    rx_done_tick = 1'b1;
    rx_data      = 8'h5A;
    tick(); tick();
    checks++; if ({alu_a, alu_b, alu_op, tx_data} !== 30'd0) begin failures++; $display("FAIL reset_regs a=%h b=%h op=%h tx=%h exp 0", alu_a, alu_b, alu_op, tx_data); end
    checks++; if (tx_start !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL reset_flags start=%b busy=%b exp 0 0", tx_start, busy); end
    rx_done_tick = 1'b0;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_add();
    int p0;
    p0 = pulse_cnt;
    run_seq(8'h05, 8'h03, 8'h20, 8'h08, 0, 0);
    checks++; if (pulse_cnt - p0 !== 1) begin failures++; $display("FAIL add_pulses got=%0d exp=1", pulse_cnt - p0); end
  endtask

  task automatic test_back_to_back();
    int p0;
    p0 = pulse_cnt;
    run_seq(8'hF0, 8'h0F, 8'h25, 8'hFF, 0, 0);
    run_seq(8'h07, 8'h02, 8'h22, 8'h05, 0, 0);
    checks++; if (pulse_cnt - p0 !== 2) begin failures++; $display("FAIL b2b_pulses got=%0d exp=2", pulse_cnt - p0); end
  endtask

  task automatic test_drop_in_wait_tx();
    run_seq(8'h31, 8'h12, 8'h26, 8'h23, 2, 1);
    run_seq(8'h40, 8'h04, 8'h20, 8'h44, 0, 0);
  endtask

  task automatic test_same_cycle_done();
    run_seq(8'h66, 8'h0F, 8'h24, 8'h06, 1, 2);
    tick();
    checks++; if (alu_a !== 8'h66 || busy !== 1'b0) begin failures++; $display("FAIL same_cycle_drop alu_a=%h busy=%b exp 66 0", alu_a, busy); end
    run_seq(8'h10, 8'h20, 8'h27, 8'hCF, 0, 0);
  endtask

  task automatic test_async_reset();
    send_byte(8'h11);
    send_byte(8'h22);
    #2;
    reset = 1'b1;
    #1;
    checks++; if ({alu_a, alu_b, alu_op, tx_data} !== 30'd0 || tx_start !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL async_reset a=%h b=%h op=%h tx=%h start=%b busy=%b exp all 0", alu_a, alu_b, alu_op, tx_data, tx_start, busy);
    end
    tick();
    reset = 1'b0;
    tick();
    run_seq(8'h01, 8'h01, 8'h20, 8'h02, 0, 0);
  endtask

  task automatic test_random();
    logic [5:0] ops [7];
    logic [7:0] a, b, opb;
    int p0;
    ops = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h3F};
    p0 = pulse_cnt;
    for (int i = 0; i < 10; i++) begin
      a   = 8'($urandom);
      b   = 8'($urandom);
      opb = 8'($urandom);
      opb[5:0] = ops[$urandom_range(0, 6)];
      run_seq(a, b, opb, alu_ref(a, b, opb[5:0]), 3, 0);
    end
    checks++; if (pulse_cnt - p0 !== 10) begin failures++; $display("FAIL random_pulses got=%0d exp=10", pulse_cnt - p0); end
  endtask

`ifdef ALU_IF_TIMEOUT_EN
  task automatic test_timeout();
    // Byte on the expiry cycle is still accepted.
    send_byte(8'h09);
    repeat (49) tick();
    send_byte(8'h33);
    send_byte(8'h20);
    finish_seq(8'h09, 8'h33, 8'h20, 8'h3C, 0);
    // Idle past expiry: back to WAIT_A, operand A kept until overwritten.
    send_byte(8'h09);
    repeat (60) tick();
    checks++; if (alu_a !== 8'h09 || busy !== 1'b0) begin failures++; $display("FAIL timeout_hold alu_a=%h busy=%b exp 09 0", alu_a, busy); end
    run_seq(8'h04, 8'h04, 8'h20, 8'h08, 0, 0);
  endtask
`else
  task automatic test_no_timeout();
    send_byte(8'h09);
    repeat (60) tick();
    send_byte(8'h33);
    send_byte(8'h20);
    finish_seq(8'h09, 8'h33, 8'h20, 8'h3C, 0);
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_drop_in_wait_tx();
    test_same_cycle_done();
    test_async_reset();
    test_random();
`ifdef ALU_IF_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
